// File: rtl/functional_unit_pipe.sv
// Tomasulo functional unit: one tagged add/sub/mul op at a time, result held on the CDB until granted (mul only with FU_MUL_EN).
// Latency: ADD_LAT edges for add/sub, MUL_LAT for mul, 1 for illegal opcodes; issue_ready stays low until the grant edge.
// Backpressure: the result is held indefinitely while cdb_grant is low; flush squashes any in-flight or held op.
module functional_unit_pipe #(
    parameter int WIDTH   = 16,
    parameter int TAG_W   = 3,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [WIDTH-1:0] cdb_data,
    output logic             cdb_illegal,
    input  logic             cdb_grant
);

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [WIDTH-1:0]   cdb_data_q, cdb_data_d;
    logic               cdb_illegal_q, cdb_illegal_d;

    logic               issue_legal;
    logic [CNT_W-1:0]   issue_lat;
    logic [WIDTH-1:0]   alu_res;

    // Opcode decode at issue time picks both legality and the countdown length.
    always_comb begin
        issue_legal = 1'b0;
        issue_lat   = CNT_W'(1);
        case (issue_op)
            OP_ADD, OP_SUB: begin
                issue_legal = 1'b1;
                issue_lat   = CNT_W'(ADD_LAT);
            end
`ifdef FU_MUL_EN
            OP_MUL: begin
                issue_legal = 1'b1;
                issue_lat   = CNT_W'(MUL_LAT);
            end
`endif
            default: begin
                issue_legal = 1'b0;
                issue_lat   = CNT_W'(1);
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = b_q + a_q;
            OP_SUB:  alu_res = b_q - a_q;
`ifdef FU_MUL_EN
            OP_MUL:  alu_res = b_q * a_q;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        a_d           = a_q;
        b_d           = b_q;
        tag_d         = tag_q;
        cdb_tag_d     = cdb_tag_q;
        cdb_data_d    = cdb_data_q;
        cdb_illegal_d = cdb_illegal_q;

        // Flush wins over everything, including an issue in the same cycle.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_valid) begin
                        op_d      = issue_op;
                        illegal_d = ~issue_legal;
                        a_d       = src_a;
                        b_d       = src_b;
                        tag_d     = issue_tag;
                        cnt_d     = issue_lat;
                        state_d   = S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d       = S_HOLD;
                        cdb_tag_d     = tag_q;
                        cdb_data_d    = illegal_q ? '0 : alu_res;
                        cdb_illegal_d = illegal_q;
                    end
                end
                S_HOLD: begin
                    if (cdb_grant) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            illegal_q     <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            tag_q         <= '0;
            cdb_tag_q     <= '0;
            cdb_data_q    <= '0;
            cdb_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            illegal_q     <= illegal_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tag_q         <= tag_d;
            cdb_tag_q     <= cdb_tag_d;
            cdb_data_q    <= cdb_data_d;
            cdb_illegal_q <= cdb_illegal_d;
        end
    end

    assign issue_ready = (state_q == S_IDLE);
    assign cdb_valid   = (state_q == S_HOLD);
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_illegal = cdb_illegal_q;

endmodule
